slon5_result_collector: RTL
===========================

SLON5_RESULT_COLLECTOR -- requirements
Module: slon5_result_collector

Interface
REQ-001 SHALL have parameter DNUM_W, default 32, width of pipeline tag (Dnum_t).
REQ-002 SHALL have parameter DOUT_W, default 64, width of pipeline result word (Dout_t).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, hit buffer entries, power of two >= 2.
REQ-004 SHALL have port clk  input  1  rising-edge clock, same clock domain as the slon5 pipeline.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  collection enable.
REQ-007 SHALL have port stop_on_hit  input  1  halt collection after first hit.
REQ-008 SHALL have port target  input  DOUT_W  unsigned compare threshold, sampled with each input.
REQ-009 SHALL have port in_valid  input  1  pipeline output valid.
REQ-010 SHALL have port in_dnum  input  DNUM_W  tag of the result word.
REQ-011 SHALL have port in_dout  input  DOUT_W  pipeline result word.
REQ-012 SHALL have port hit_valid  output  1  hit FIFO head valid.
REQ-013 SHALL have port hit_ready  input  1  consumer accepts head.
REQ-014 SHALL have port hit_dnum  output  DNUM_W  tag of head hit.
REQ-015 SHALL have port hit_dout  output  DOUT_W  result word of head hit.
REQ-016 SHALL have port proc_cnt  output  32  accepted results, saturating.
REQ-017 SHALL have port hit_cnt  output  16  detected hits, saturating.
REQ-018 SHALL have port overflow  output  1  sticky: hit dropped on full FIFO.
REQ-019 SHALL have port state  output  2  FSM state code (IDLE=0, RUN=1, DONE=2).

Function
REQ-020 SHALL implement FSM: IDLE -> RUN when en=1; RUN -> IDLE when en=0; RUN -> DONE when stop_on_hit=1 and a hit is pushed; DONE -> IDLE only when en=0.
REQ-021 SHALL accept a result only when in_valid=1 and state=RUN in that cycle; other inputs ignored, counters unchanged.
REQ-022 SHALL classify an accepted result as hit when in_dout < target (unsigned, full DOUT_W compare); equality is not a hit.
REQ-023 SHALL register accepted result, tag and hit flag in stage 1 (cycle N+1); hit pushes into FIFO at end of N+1; hit_valid high from N+2 when FIFO was empty.
REQ-024 SHALL increment proc_cnt by 1 per accepted result in stage 1, holding at 32'hFFFF_FFFF.
REQ-025 SHALL increment hit_cnt by 1 per stage-1 hit, including dropped hits, holding at 16'hFFFF.
REQ-026 SHALL in stop_on_hit mode enter DONE in the cycle after the first hit reaches stage 1; results accepted in N+1 while still RUN are processed normally (at most one extra).
REQ-027 SHALL pop FIFO head when hit_valid=1 and hit_ready=1; hit_dnum/hit_dout stable while hit_valid=1 and hit_ready=0.
REQ-028 SHALL on push to full FIFO with no pop drop the new hit and set overflow=1 until rst.
REQ-029 SHALL on simultaneous push and pop with full FIFO perform both; no drop, overflow unchanged.
REQ-030 SHALL on push to empty FIFO present the entry no earlier than the following cycle (no combinational bypass).
REQ-031 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, preserving order.
REQ-032 SHALL keep FIFO contents and counters across IDLE/RUN/DONE transitions; only rst clears them.
REQ-033 SHALL drive hit_dnum/hit_dout to zero when hit_valid=0.

Reset
REQ-034 SHALL on rst=1 at a clock edge set state=IDLE, hit_valid=0, hit_dnum=0, hit_dout=0, proc_cnt=0, hit_cnt=0, overflow=0, FIFO empty, stage-1 valid cleared.
REQ-035 SHALL on rst mid-operation discard stage-1 and FIFO contents; no push occurs in the reset cycle.
REQ-036 SHALL after rst release require en=1 sampled in IDLE before accepting results (first acceptance one cycle after en seen).

Verification
REQ-037 SHALL cover: en=1, target=100, stream dnum 0..9 with dout=dnum*20 -> hits dnum 0..4 in order, hit_cnt=5, proc_cnt=10, overflow=0.
REQ-038 SHALL cover: hit_ready=0, 6 consecutive hits, FIFO_DEPTH=4 -> 4 entries held (first four tags), overflow=1, hit_cnt=6.
REQ-039 SHALL cover: full FIFO, hit_ready=1 with simultaneous push -> no drop, overflow stays 0, occupancy stays 4.
REQ-040 SHALL cover: stop_on_hit=1, dout=200,50,10 back-to-back, target=100 -> state=DONE, hits dnum 1 and 2 only, later inputs ignored, proc_cnt=3.
REQ-041 SHALL cover: rst asserted with 3 FIFO entries and in_valid=1 -> next cycle all outputs at reset values, hit_valid=0.
REQ-042 SHALL cover: dout==target=0x1234 -> not a hit; proc_cnt=1, hit_cnt=0.

Source files
------------

// File: rtl/slon5_result_collector.sv
// Collects slon5 pipeline results, flags those below a target as hits and
// buffers hit tags/words in a small FIFO, with saturating statistics counters.
module slon5_result_collector #(
    parameter int DNUM_W     = 32,
    parameter int DOUT_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stop_on_hit,
    input  logic [DOUT_W-1:0] target,
    input  logic              in_valid,
    input  logic [DNUM_W-1:0] in_dnum,
    input  logic [DOUT_W-1:0] in_dout,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [DNUM_W-1:0] hit_dnum,
    output logic [DOUT_W-1:0] hit_dout,
    output logic [31:0]       proc_cnt,
    output logic [15:0]       hit_cnt,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_hit_q, s1_hit_d;
    logic [DNUM_W-1:0] s1_dnum_q, s1_dnum_d;
    logic [DOUT_W-1:0] s1_dout_q, s1_dout_d;
    logic [DNUM_W-1:0] mem_dnum_q [FIFO_DEPTH];
    logic [DNUM_W-1:0] mem_dnum_d [FIFO_DEPTH];
    logic [DOUT_W-1:0] mem_dout_q [FIFO_DEPTH];
    logic [DOUT_W-1:0] mem_dout_d [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [31:0]       proc_cnt_q, proc_cnt_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic              overflow_q, overflow_d;

    logic accept_s, push_req_s, empty_s, full_s, pop_s, push_s, drop_s;

    // Hit handshake and FIFO occupancy decode.
    always_comb begin
        accept_s   = in_valid && (state_q == ST_RUN);
        push_req_s = s1_valid_q && s1_hit_q;
        empty_s    = (count_q == {(AW+1){1'b0}});
        full_s     = (count_q == (AW+1)'(FIFO_DEPTH));
        pop_s      = !empty_s && hit_ready;
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;
    end

    // Collection FSM; the stop condition is the first hit reaching stage 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
                else    state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!en)                             state_d = ST_IDLE;
                else if (stop_on_hit && push_req_s)  state_d = ST_DONE;
                else                                 state_d = ST_RUN;
            end
            ST_DONE: begin
                if (!en) state_d = ST_IDLE;
                else     state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1 capture and saturating statistics.
    always_comb begin
        s1_valid_d = accept_s;
        s1_hit_d   = accept_s && (in_dout < target);
        s1_dnum_d  = accept_s ? in_dnum : s1_dnum_q;
        s1_dout_d  = accept_s ? in_dout : s1_dout_q;

        proc_cnt_d = proc_cnt_q;
        if (s1_valid_q && (proc_cnt_q != 32'hFFFF_FFFF)) proc_cnt_d = proc_cnt_q + 32'd1;
        else                                             proc_cnt_d = proc_cnt_q;

        hit_cnt_d = hit_cnt_q;
        if (push_req_s && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
        else                                       hit_cnt_d = hit_cnt_q;

        overflow_d = overflow_q || drop_s;
    end

    // Hit FIFO storage and pointers; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        mem_dnum_d = mem_dnum_q;
        mem_dout_d = mem_dout_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            mem_dnum_d[wr_ptr_q] = s1_dnum_q;
            mem_dout_d[wr_ptr_q] = s1_dout_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
        else       rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_dnum_q  <= {DNUM_W{1'b0}};
            s1_dout_q  <= {DOUT_W{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            proc_cnt_q <= 32'd0;
            hit_cnt_q  <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_dnum_q  <= s1_dnum_d;
            s1_dout_q  <= s1_dout_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            proc_cnt_q <= proc_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO payload needs no reset: it is only visible through a non-zero count.
    always_ff @(posedge clk) begin
        mem_dnum_q <= mem_dnum_d;
        mem_dout_q <= mem_dout_d;
    end

    assign hit_valid = !empty_s;
    assign hit_dnum  = empty_s ? {DNUM_W{1'b0}} : mem_dnum_q[rd_ptr_q];
    assign hit_dout  = empty_s ? {DOUT_W{1'b0}} : mem_dout_q[rd_ptr_q];
    assign proc_cnt  = proc_cnt_q;
    assign hit_cnt   = hit_cnt_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

endmodule
